// File: rtl/tile_row_fetch_if.sv
// tile_row_fetch_if: pattern-word stream from the tile fetcher to the pixel shifter.
// The master (fetcher) drives the valid, data, column and last signals. The slave
// (shifter) drives ready. A word transfers on a cycle where valid and ready are both high.
interface tile_row_fetch_if #(
    parameter int PAT_BITS = 32,
    parameter int COL_W    = 7
);
    logic                out_valid;
    logic                out_ready;
    logic [PAT_BITS-1:0] out_data;
    logic [COL_W-1:0]    out_col;
    logic                out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_col,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_col,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/tile_row_fetch.sv
// tile_row_fetch: per-scanline tile fetcher.
// On line_start it walks the COLS tile columns of the requested scanline.
// For each column it reads the tile index from the map RAM, then reads that
// tile's pattern row from the pattern RAM. It emits one pattern word per column
// on a valid/ready stream.
// Both RAMs are read through a 1-cycle registered read port with no read enable.
// Optional feature: define TILE_FLIP_EN to treat the map entry MSB as a
// horizontal-flip flag. The default build has no flip.
module tile_row_fetch #(
    parameter int COLS     = 80,
    parameter int ROWS     = 60,
    parameter int MAP_BITS = 8,
    parameter int BPP      = 4,
    parameter int MAP_AW   = 13,
    parameter int ROW_BITS = 9
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  line_start,
    input  logic [ROW_BITS-1:0]   line_row,
    output logic                  busy,
    output logic                  overrun,
    output logic [MAP_AW-1:0]     map_addr,
    input  logic [MAP_BITS-1:0]   map_dout,
    output logic [MAP_BITS+2:0]   pat_addr,
    input  logic [8*BPP-1:0]      pat_dout,
    tile_row_fetch_if.master      out_if
);
    localparam int               PAT_BITS   = 8 * BPP;
    localparam int               COL_W      = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int               PAT_AW     = MAP_BITS + 3;
    localparam logic [COL_W-1:0] LAST_COL   = COL_W'(COLS - 1);
    localparam logic [31:0]      LINE_COUNT = 32'(ROWS * 8);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MAP  = 3'd1,
        S_PAT  = 3'd2,
        S_LOAD = 3'd3,
        S_OUT  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [COL_W-1:0]    r_col;
    logic [COL_W-1:0]    w_col_inc;
    logic [MAP_AW-1:0]   r_row_base;
    logic [MAP_AW-1:0]   w_row_base;
    logic [MAP_AW-1:0]   r_map_addr;
    logic [2:0]          r_fine;
    logic [PAT_AW-1:0]   r_pat_addr;
    logic [PAT_AW-1:0]   w_pat_addr;
    logic [MAP_BITS-1:0] w_tile_idx;
    logic [PAT_BITS-1:0] w_load_word;
    logic [PAT_BITS-1:0] r_out_data;
    logic [COL_W-1:0]    r_out_col;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_overrun;

    logic                w_row_ok;
    logic                w_accept;
    logic                w_handshake;
    logic                w_busy;

    // Address of the first tile of the tile row that contains the scanline.
    // The product always fits in MAP_AW bits because 2**MAP_AW >= COLS*ROWS.
    assign w_row_base = MAP_AW'(line_row >> 3) * MAP_AW'(COLS);
    assign w_col_inc  = r_col + COL_W'(1);

`ifdef TILE_FLIP_EN
    logic                r_flip;
    logic [PAT_BITS-1:0] w_flipped;

    // The top map bit is the flip flag, so only the lower bits select the tile.
    assign w_tile_idx = {1'b0, map_dout[MAP_BITS-2:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_flip
            assign w_flipped[BPP*gi +: BPP] = pat_dout[BPP*(7-gi) +: BPP];
        end
    endgenerate

    // Capture the flip flag while map_dout is valid (PAT), for use in LOAD.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flip <= 1'b0;
        end else if (r_state == S_PAT) begin
            r_flip <= map_dout[MAP_BITS-1];
        end
    end

    assign w_load_word = r_flip ? w_flipped : pat_dout;
`else
    assign w_tile_idx  = map_dout;
    assign w_load_word = pat_dout;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: MAP/PAT/LOAD are single cycles. OUT waits for the handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_MAP;
            S_MAP:   w_state_next = S_PAT;
            S_PAT:   w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_OUT;
            S_OUT: begin
                if (out_if.out_ready) begin
                    w_state_next = r_out_last ? S_IDLE : S_MAP;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Decoded controls. In PAT the pattern address comes straight from map_dout.
    // A registered copy keeps pat_addr steady outside PAT.
    always_comb begin
        w_busy      = (r_state != S_IDLE);
        w_row_ok    = (32'(line_row) < LINE_COUNT);
        w_accept    = (r_state == S_IDLE) && line_start && w_row_ok;
        w_handshake = (r_state == S_OUT) && out_if.out_ready;
        w_pat_addr  = (r_state == S_PAT) ? {w_tile_idx, r_fine} : r_pat_addr;
    end

    // Datapath: line context, RAM addresses, output word and overrun pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_col       <= '0;
            r_row_base  <= '0;
            r_fine      <= '0;
            r_map_addr  <= '0;
            r_pat_addr  <= '0;
            r_out_data  <= '0;
            r_out_col   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            // A line_start is an overrun when a line is still in progress.
            // This includes the cycle of the final handshake.
            r_overrun <= line_start && w_busy;

            if (w_accept) begin
                r_col      <= '0;
                r_row_base <= w_row_base;
                r_fine     <= line_row[2:0];
                r_map_addr <= w_row_base;
            end

            if (r_state == S_PAT) begin
                r_pat_addr <= w_pat_addr;
            end

            if (r_state == S_LOAD) begin
                r_out_data  <= w_load_word;
                r_out_col   <= r_col;
                r_out_last  <= (r_col == LAST_COL);
                r_out_valid <= 1'b1;
            end

            if (w_handshake) begin
                r_out_valid <= 1'b0;
                if (!r_out_last) begin
                    r_col      <= w_col_inc;
                    r_map_addr <= r_row_base + MAP_AW'(w_col_inc);
                end
            end
        end
    end

    assign busy             = w_busy;
    assign overrun          = r_overrun;
    assign map_addr         = r_map_addr;
    assign pat_addr         = w_pat_addr;
    assign out_if.out_valid = r_out_valid;
    assign out_if.out_data  = r_out_data;
    assign out_if.out_col   = r_out_col;
    assign out_if.out_last  = r_out_last;

    // A stalled word must not change until the shifter takes it.
    a_hold_while_stalled: assert property (
        @(posedge clk) disable iff (!reset_n)
        (r_out_valid && !out_if.out_ready) |=>
            (r_out_valid && $stable(r_out_data) && $stable(r_out_col))
    );

    // out_last marks exactly the final column of the line.
    a_last_on_final_col: assert property (
        @(posedge clk) disable iff (!reset_n)
        r_out_valid |-> (r_out_last == (r_out_col == LAST_COL))
    );
endmodule

// File: tb/tb_tile_row_fetch.sv
// tb_tile_row_fetch: scoreboard bench for tile_row_fetch with behavioural RAMs.
// Each accepted line_start pushes the line's expected words, computed from the
// map and pattern tables. A separate negedge monitor pops one expected word on
// each handshake and compares it with the DUT output.
module tb_tile_row_fetch;
    localparam int COLS     = 80;
    localparam int ROWS     = 60;
    localparam int MAP_BITS = 8;
    localparam int BPP      = 4;
    localparam int MAP_AW   = 13;
    localparam int ROW_BITS = 9;
    localparam int PAT_BITS = 8 * BPP;
    localparam int COL_W    = $clog2(COLS);
    localparam int PAT_AW   = MAP_BITS + 3;
    localparam int LINES    = ROWS * 8;

    typedef struct {
        logic [PAT_BITS-1:0] data;
        logic [COL_W-1:0]    col;
        logic                last;
        logic [MAP_AW-1:0]   maddr;
        logic [PAT_AW-1:0]   paddr;
    } exp_t;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                line_start = 1'b0;
    logic [ROW_BITS-1:0] line_row = '0;
    logic                busy;
    logic                overrun;
    logic [MAP_AW-1:0]   map_addr;
    logic [MAP_BITS-1:0] map_dout;
    logic [PAT_AW-1:0]   pat_addr;
    logic [PAT_BITS-1:0] pat_dout;

    logic [MAP_BITS-1:0] map_mem [0:(1<<MAP_AW)-1];
    logic [PAT_BITS-1:0] pat_mem [0:(1<<PAT_AW)-1];
    logic [PAT_BITS-1:0] got_data [0:COLS-1];

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   exp_ovr    = 0;
    int   ovr_cycles = 0;
    int   n_words    = 0;
    bit   model_busy = 1'b0;
    bit   held_valid = 1'b0;
    logic [PAT_BITS-1:0] held_data = '0;
    logic [COL_W-1:0]    held_col = '0;

    tile_row_fetch_if #(.PAT_BITS(PAT_BITS), .COL_W(COL_W)) sif ();

    tile_row_fetch #(
        .COLS(COLS), .ROWS(ROWS), .MAP_BITS(MAP_BITS),
        .BPP(BPP), .MAP_AW(MAP_AW), .ROW_BITS(ROW_BITS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .line_row   (line_row),
        .busy       (busy),
        .overrun    (overrun),
        .map_addr   (map_addr),
        .map_dout   (map_dout),
        .pat_addr   (pat_addr),
        .pat_dout   (pat_dout),
        .out_if     (sif.master)
    );

    always #5 clk = ~clk;

    // Registered-read RAM models, as in the tilemap and pattern block RAMs.
    always @(posedge clk) begin
        map_dout <= map_mem[map_addr];
        pat_dout <= pat_mem[pat_addr];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [PAT_BITS-1:0] flip_word(input logic [PAT_BITS-1:0] w);
        logic [PAT_BITS-1:0] r;
        r = '0;
        for (int p = 0; p < 8; p++) r[BPP*(7-p) +: BPP] = w[BPP*p +: BPP];
        return r;
    endfunction

    // Reference model: the expected words of one scanline, from the table contents.
    task automatic push_line(input int row);
        for (int c = 0; c < COLS; c++) begin
            exp_t                x;
            logic [MAP_BITS-1:0] e;
            logic [MAP_BITS-1:0] tile;
            logic                fl;
            x.maddr = MAP_AW'((row / 8) * COLS + c);
            e = map_mem[x.maddr];
`ifdef TILE_FLIP_EN
            fl   = e[MAP_BITS-1];
            tile = {1'b0, e[MAP_BITS-2:0]};
`else
            fl   = 1'b0;
            tile = e;
`endif
            x.paddr = {tile, 3'(row % 8)};
            x.data  = fl ? flip_word(pat_mem[x.paddr]) : pat_mem[x.paddr];
            x.col   = COL_W'(c);
            x.last  = (c == COLS - 1);
            exp_q.push_back(x);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"},      64'(busy),          64'(0));
        check({tag, "_overrun"},   64'(overrun),       64'(0));
        check({tag, "_out_valid"}, 64'(sif.out_valid), 64'(0));
        check({tag, "_out_last"},  64'(sif.out_last),  64'(0));
        check({tag, "_out_data"},  64'(sif.out_data),  64'(0));
        check({tag, "_out_col"},   64'(sif.out_col),   64'(0));
        check({tag, "_map_addr"},  64'(map_addr),      64'(0));
        check({tag, "_pat_addr"},  64'(pat_addr),      64'(0));
    endtask

    task automatic start_line(input int row);
        line_row   = ROW_BITS'(row);
        line_start = 1'b1;
        if (model_busy) begin
            exp_ovr++;
        end else if (row < LINES) begin
            push_line(row);
            model_busy = 1'b1;
        end
        tick();
        line_start = 1'b0;
    endtask

    // Drive out_ready until the model sees the line's last word accepted.
    // Optional events are a 10-cycle stall at stall_col, a line_start at
    // ovr_col and on the final handshake, and a reset at rst_col.
    task automatic run_line(input int row, input int pct, input int stall_col,
                            input int ovr_col, input bit ovr_last, input int rst_col);
        int cyc        = 0;
        int stall_left = 10;
        bit ovr_done   = 1'b0;
        forever begin
            if (!model_busy) break;
            if (cyc >= 4000) begin
                check("line_within_budget", 64'(model_busy), 64'(0));
                exp_q.delete();
                model_busy = 1'b0;
                break;
            end
            line_start = 1'b0;
            out_if_ready_set($urandom_range(0, 99) < pct);
            if (sif.out_valid && int'(sif.out_col) == stall_col && stall_left > 0) begin
                out_if_ready_set(1'b0);
                stall_left--;
            end
            if (sif.out_valid && int'(sif.out_col) == ovr_col && !ovr_done) begin
                line_row   = ROW_BITS'(7);
                line_start = 1'b1;
                exp_ovr++;
                ovr_done   = 1'b1;
            end
            if (ovr_last && sif.out_valid && sif.out_last) begin
                out_if_ready_set(1'b1);
                line_row   = ROW_BITS'(7);
                line_start = 1'b1;
                exp_ovr++;
            end
            if (sif.out_valid && int'(sif.out_col) == rst_col) begin
                reset_n = 1'b0;
                #1;
                check_zero_outputs("reset_midline");
                exp_q.delete();
                model_busy = 1'b0;
                tick();
                tick();
                reset_n = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    tick();
                    check("idle_after_reset_busy",  64'(busy),          64'(0));
                    check("idle_after_reset_valid", 64'(sif.out_valid), 64'(0));
                end
                $display("line row=%0d aborted by reset at col %0d", row, rst_col);
                return;
            end
            tick();
            cyc++;
        end
        line_start = 1'b0;
        check("busy_after_line",  64'(busy),          64'(0));
        check("valid_after_line", 64'(sif.out_valid), 64'(0));
        $display("line row=%0d done in %0d cycles, words so far %0d", row, cyc, n_words);
    endtask

    task automatic out_if_ready_set(input bit v);
        sif.out_ready = v;
    endtask

    // Monitor: compare each accepted word with the scoreboard head.
    // Also check that a stalled word holds stable, and count overrun cycles.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (overrun) ovr_cycles++;
                if (sif.out_valid && held_valid) begin
                    check("hold_data", 64'(sif.out_data), 64'(held_data));
                    check("hold_col",  64'(sif.out_col),  64'(held_col));
                end
                if (sif.out_valid && sif.out_ready) begin
                    held_valid = 1'b0;
                    check("word_expected", 64'(exp_q.size() > 0), 64'(1));
                    if (exp_q.size() > 0) begin
                        x = exp_q.pop_front();
                        check("out_data", 64'(sif.out_data), 64'(x.data));
                        check("out_col",  64'(sif.out_col),  64'(x.col));
                        check("out_last", 64'(sif.out_last), 64'(x.last));
                        check("map_addr", 64'(map_addr),     64'(x.maddr));
                        check("pat_addr", 64'(pat_addr),     64'(x.paddr));
                        check("busy_during_line", 64'(busy), 64'(1));
                        got_data[x.col] = sif.out_data;
                        n_words++;
                        if (x.last) model_busy = 1'b0;
                    end
                end else if (sif.out_valid) begin
                    held_valid = 1'b1;
                    held_data  = sif.out_data;
                    held_col   = sif.out_col;
                end else begin
                    held_valid = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        for (int i = 0; i < (1 << MAP_AW); i++) map_mem[i] = MAP_BITS'($urandom);
        for (int i = 0; i < (1 << PAT_AW); i++) pat_mem[i] = PAT_BITS'($urandom);
        for (int c = 0; c < COLS; c++) map_mem[c] = MAP_BITS'(c);
        // Flip test entries in tile row 1 (scanlines 8..15).
        map_mem[COLS]     = 8'h83;
        map_mem[COLS + 1] = 8'h03;
        pat_mem[3 * 8]    = 32'h76543210;

        sif.out_ready = 1'b1;
        repeat (3) tick();
        check_zero_outputs("reset");
        reset_n = 1'b1;
        tick();
        check_zero_outputs("after_release");

        // Row 0 with identity map, ready always high, first-word latency.
        start_line(0);
        n = 0;
        while (!sif.out_valid && n < 10) begin
            tick();
            n++;
        end
        check("first_valid_latency", 64'(n), 64'(3));
        run_line(0, 100, -1, -1, 1'b0, -1);

        // Row 13: map addresses 80..159 and fine row 5.
        start_line(13);
        run_line(13, 100, -1, -1, 1'b0, -1);

        // Row 8: flip entries in columns 0 and 1.
        start_line(8);
        run_line(8, 100, -1, -1, 1'b0, -1);
        check("tile3_unflipped", 64'(got_data[1]), 64'(32'h76543210));
`ifdef TILE_FLIP_EN
        check("tile3_flipped", 64'(got_data[0]), 64'(32'h01234567));
`endif

        // Stall 10 cycles at col 5.
        n = $urandom_range(0, LINES - 1);
        start_line(n);
        run_line(n, 100, 5, -1, 1'b0, -1);

        // Overrun at col 40 and on the final handshake.
        n = $urandom_range(0, LINES - 1);
        start_line(n);
        run_line(n, 100, -1, 40, 1'b1, -1);
        tick();
        tick();
        check("overrun_pulses_after_ovr_line", 64'(ovr_cycles), 64'(exp_ovr));

        // Out-of-range row is ignored.
        start_line(480);
        for (int k = 0; k < 8; k++) begin
            check("row480_busy",    64'(busy),          64'(0));
            check("row480_valid",   64'(sif.out_valid), 64'(0));
            check("row480_overrun", 64'(overrun),       64'(0));
            tick();
        end
        $display("line row=480 ignored");

        // Reset mid-line at col 20, then a normal line afterwards.
        n = $urandom_range(0, LINES - 1);
        start_line(n);
        run_line(n, 100, -1, -1, 1'b0, 20);
        start_line(LINES - 1);
        run_line(LINES - 1, 100, -1, -1, 1'b0, -1);

        // Random rows with random backpressure.
        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(0, LINES - 1);
            start_line(n);
            run_line(n, 70, -1, -1, 1'b0, -1);
        end

        repeat (3) tick();
        check("overrun_pulses_total", 64'(ovr_cycles), 64'(exp_ovr));
        check("scoreboard_drained",   64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
